// File: rtl/rw_if_pkg.sv
// Shared definitions for the CPU read/write bus interface: FSM state
// encoding, control-register address and the address-to-target decode.
package rw_if_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        CONFLICT
    } state_t;

    // Synchronisers shallower than this do not give metastability margin.
    localparam int MIN_SYNC_STG = 2;

    // The control-word register sits at the top of the address space.
    function automatic int ctrl_addr(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

    // One bit of the one-hot target vector: index idx < num_ch is a counter
    // channel, index num_ch is the control register. Addresses that hit
    // neither leave every bit clear (unmapped access).
    function automatic logic target_hit(input int addr, input int idx,
                                        input int num_ch, input int addr_w);
        if (idx < num_ch) begin
            return addr == idx;
        end
        return addr == ctrl_addr(addr_w);
    endfunction

endpackage

// File: rtl/rw_bus_interface_if.sv
// CPU-side strobes/buses plus the decoded outputs towards the counter
// channels and control register, bundled as one interface.
interface rw_bus_interface_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
);
    logic              RD_n;
    logic              WR_n;
    logic              CS_n;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] D_in;
    logic [NUM_CH:0]   wr_pulse;
    logic [DATA_W-1:0] wr_data;
    logic [NUM_CH:0]   rd_sel;
    logic              rd_done;
    logic              bus_oe;
    logic              err;

    // CPU / bus-model side
    modport master (
        output RD_n, WR_n, CS_n, A, D_in,
        input  wr_pulse, wr_data, rd_sel, rd_done, bus_oe, err
    );

    // Interface block side
    modport slave (
        input  RD_n, WR_n, CS_n, A, D_in,
        output wr_pulse, wr_data, rd_sel, rd_done, bus_oe, err
    );
endinterface

// File: rtl/bus_sync.sv
// Multi-stage synchroniser for a bundle of asynchronous inputs. Every bit
// goes through the same number of flops so related signals stay aligned.
module bus_sync #(
    parameter int              WIDTH   = 1,
    parameter int              STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    // Each stage takes the previous one; stage 0 takes the raw input.
    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Pipe registers, preset to the idle value of the bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[STAGES-1];
endmodule

// File: rtl/rw_bus_interface.sv
// CPU read/write bus interface for the timer core. Synchronises the CPU
// strobes and buses, then turns each access into a one-cycle write pulse
// (with latched data), a read-select level plus read-done pulse, or a
// sticky error when read and write are asserted together.
module rw_bus_interface
    import rw_if_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 8,
    parameter int SYNC_STG = 2
) (
    input logic          clk,
    input logic          rst,
    rw_bus_interface_if.slave bus
);
    localparam int AD_W = ADDR_W + DATA_W;

    if (NUM_CH < 1 || NUM_CH >= (1 << ADDR_W) || SYNC_STG < MIN_SYNC_STG) begin : g_param_check
        $error("rw_bus_interface: need 1 <= NUM_CH < 2**ADDR_W and SYNC_STG >= 2");
    end

    logic [2:0]        strb_sync;
    logic [AD_W-1:0]   ad_sync;
    logic              s_rd, s_wr, s_cs;
    logic [ADDR_W-1:0] s_a;
    logic [DATA_W-1:0] s_d;
    logic [NUM_CH:0]   tgt_now;

    // Strobes idle high, address/data idle low; identical depth keeps
    // the address and data aligned with the strobe that qualifies them.
    bus_sync #(.WIDTH(3), .STAGES(SYNC_STG), .RST_VAL(3'b111)) u_sync_strb (
        .clk (clk),
        .rst (rst),
        .d   ({bus.RD_n, bus.WR_n, bus.CS_n}),
        .q   (strb_sync)
    );

    bus_sync #(.WIDTH(AD_W), .STAGES(SYNC_STG), .RST_VAL('0)) u_sync_ad (
        .clk (clk),
        .rst (rst),
        .d   ({bus.A, bus.D_in}),
        .q   (ad_sync)
    );

    assign {s_rd, s_wr, s_cs} = strb_sync;
    assign {s_a, s_d}         = ad_sync;

    genvar gi;
    for (gi = 0; gi <= NUM_CH; gi++) begin : g_decode
        assign tgt_now[gi] = target_hit(int'(s_a), gi, NUM_CH, ADDR_W);
    end

    state_t            state_q, state_d;
    logic [NUM_CH:0]   target_q, target_d;
    logic [NUM_CH:0]   wr_pulse_q, wr_pulse_d;
    logic [NUM_CH:0]   rd_sel_q, rd_sel_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rd_done_q, rd_done_d;
    logic              bus_oe_q, bus_oe_d;
    logic              err_q, err_d;
    logic              conflict;

    assign conflict = !s_cs && !s_rd && !s_wr;

    // Next-state and output decode; pulses and read levels default low.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        wr_pulse_d = '0;
        wr_data_d  = wr_data_q;
        rd_sel_d   = '0;
        rd_done_d  = 1'b0;
        bus_oe_d   = 1'b0;
        err_d      = err_q;

        if (conflict) begin
            // Simultaneous read and write wins over any access in flight.
            state_d = CONFLICT;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!s_cs && !s_wr) begin
                        state_d   = WRITE;
                        target_d  = tgt_now;
                        wr_data_d = s_d;
                    end else if (!s_cs && !s_rd) begin
                        state_d  = READ;
                        target_d = tgt_now;
                        rd_sel_d = tgt_now;
                        bus_oe_d = |tgt_now;
                    end
                end
                WRITE: begin
                    if (s_cs) begin
                        state_d = IDLE;
                    end else if (s_wr) begin
                        wr_pulse_d = target_q;
                        state_d    = IDLE;
                    end else begin
                        // Keep following the data until the strobe lifts.
                        wr_data_d = s_d;
                    end
                end
                READ: begin
                    if (s_cs) begin
                        state_d = IDLE;
                    end else if (s_rd) begin
                        rd_done_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        // Target frozen at entry; address changes are ignored.
                        rd_sel_d = target_q;
                        bus_oe_d = |target_q;
                    end
                end
                CONFLICT: begin
                    if (s_rd && s_wr) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            target_q   <= '0;
            wr_pulse_q <= '0;
            wr_data_q  <= '0;
            rd_sel_q   <= '0;
            rd_done_q  <= 1'b0;
            bus_oe_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            wr_pulse_q <= wr_pulse_d;
            wr_data_q  <= wr_data_d;
            rd_sel_q   <= rd_sel_d;
            rd_done_q  <= rd_done_d;
            bus_oe_q   <= bus_oe_d;
            err_q      <= err_d;
        end
    end

    assign bus.wr_pulse = wr_pulse_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.rd_sel   = rd_sel_q;
    assign bus.rd_done  = rd_done_q;
    assign bus.bus_oe   = bus_oe_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_rw_bus_interface.sv
// Bench for rw_bus_interface. Three configurations share one CPU stimulus:
// k=0 defaults (3 ch, 2-bit addr, 8-bit data), k=1 two channels (address 2
// unmapped), k=2 five channels, 3-bit address, 16-bit data.
module tb_rw_bus_interface;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_n = 1'b1;
    logic        wr_n = 1'b1;
    logic        cs_n = 1'b1;
    logic [2:0]  a = '0;
    logic [15:0] d = '0;

    int n_cmp = 0;
    int n_bad = 0;

    int nch [3] = '{3, 2, 5};
    int aw  [3] = '{2, 2, 3};
    int dw  [3] = '{8, 8, 16};

    logic [15:0] exp_wd  [3];
    logic        exp_err [3];

    // Packed observation: {wr_pulse[5:0], wr_data[15:0], rd_sel[5:0], rd_done, bus_oe, err}
    localparam logic [30:0] WD_OFF = {6'h3F, 16'h0000, 9'h1FF};

    always #5 clk = ~clk;

    rw_bus_interface_if #(.NUM_CH(3), .ADDR_W(2), .DATA_W(8))  bus_a ();
    rw_bus_interface_if #(.NUM_CH(2), .ADDR_W(2), .DATA_W(8))  bus_c ();
    rw_bus_interface_if #(.NUM_CH(5), .ADDR_W(3), .DATA_W(16)) bus_b ();

    assign bus_a.RD_n = rd_n;  assign bus_a.WR_n = wr_n;  assign bus_a.CS_n = cs_n;
    assign bus_a.A    = a[1:0]; assign bus_a.D_in = d[7:0];
    assign bus_c.RD_n = rd_n;  assign bus_c.WR_n = wr_n;  assign bus_c.CS_n = cs_n;
    assign bus_c.A    = a[1:0]; assign bus_c.D_in = d[7:0];
    assign bus_b.RD_n = rd_n;  assign bus_b.WR_n = wr_n;  assign bus_b.CS_n = cs_n;
    assign bus_b.A    = a;      assign bus_b.D_in = d;

    rw_bus_interface #(.NUM_CH(3), .ADDR_W(2), .DATA_W(8), .SYNC_STG(2)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    rw_bus_interface #(.NUM_CH(2), .ADDR_W(2), .DATA_W(8), .SYNC_STG(2)) dut_c (
        .clk (clk), .rst (rst), .bus (bus_c)
    );
    rw_bus_interface #(.NUM_CH(5), .ADDR_W(3), .DATA_W(16), .SYNC_STG(2)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    // Reference decode: channel i at address i, control at the top address.
    function automatic logic [5:0] exp_tgt(input int k, input logic [2:0] addr);
        int am;
        am = int'(addr) % (1 << aw[k]);
        if (am < nch[k]) return 6'(1 << am);
        if (am == (1 << aw[k]) - 1) return 6'(1 << nch[k]);
        return 6'd0;
    endfunction

    function automatic logic [15:0] dmask(input int k);
        return (dw[k] == 16) ? 16'hFFFF : 16'h00FF;
    endfunction

    function automatic logic [30:0] pack(input logic [5:0] wp, input logic [15:0] wd,
                                         input logic [5:0] rs, input logic rdd,
                                         input logic oe, input logic er);
        return {wp, wd, rs, rdd, oe, er};
    endfunction

    function automatic logic [30:0] obs(input int k);
        case (k)
            0: return pack({2'b00, bus_a.wr_pulse}, {8'h00, bus_a.wr_data}, {2'b00, bus_a.rd_sel},
                           bus_a.rd_done, bus_a.bus_oe, bus_a.err);
            1: return pack({3'b000, bus_c.wr_pulse}, {8'h00, bus_c.wr_data}, {3'b000, bus_c.rd_sel},
                           bus_c.rd_done, bus_c.bus_oe, bus_c.err);
            default: return pack(bus_b.wr_pulse, bus_b.wr_data, bus_b.rd_sel,
                                 bus_b.rd_done, bus_b.bus_oe, bus_b.err);
        endcase
    endfunction

    task automatic test_reset();
        logic [30:0] act;
        rst = 1'b1; rd_n = 1'b1; wr_n = 1'b1; cs_n = 1'b1; a = '0; d = '0;
        for (int k = 0; k < 3; k++) begin exp_wd[k] = '0; exp_err[k] = 1'b0; end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            act = obs(k); n_cmp++;
            if (act !== 31'd0) begin
                $display("FAIL reset_hold dut%0d: got %h, expected %h", k, act, 31'd0); n_bad++;
            end
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            act = obs(k); n_cmp++;
            if (act !== 31'd0) begin
                $display("FAIL reset_idle dut%0d: got %h, expected %h", k, act, 31'd0); n_bad++;
            end
        end
        $display("reset: outputs checked during and after reset");
    endtask

    // One write: pulse exactly 3 edges after WR_n rises, data latched.
    task automatic test_write(input logic [2:0] addr, input logic [15:0] data, input int hold);
        logic [30:0] act, exp, msk;
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; a = addr; d = data;
        repeat (hold) @(negedge clk);
        wr_n = 1'b1;
        for (int k = 0; k < 3; k++) exp_wd[k] = data & dmask(k);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                exp = pack((n == 3) ? exp_tgt(k, addr) : 6'd0, exp_wd[k], 6'd0, 1'b0, 1'b0, exp_err[k]);
                msk = (n < 3) ? WD_OFF : '1;
                act = obs(k); n_cmp++;
                if ((act & msk) !== (exp & msk)) begin
                    $display("FAIL write dut%0d a=%0d cyc%0d: got %h, expected %h", k, addr, n, act, exp);
                    n_bad++;
                end
            end
        end
        cs_n = 1'b1;
        $display("write a=%0d d=%h hold=%0d", addr, data, hold);
    endtask

    // One read: rd_sel/bus_oe from the 3rd edge, rd_done 3 edges after RD_n rises.
    task automatic test_read(input logic [2:0] addr, input int hold);
        logic [30:0] act, exp;
        logic [5:0]  t;
        @(negedge clk);
        cs_n = 1'b0; rd_n = 1'b0; a = addr;
        for (int n = 1; n <= hold; n++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                t   = exp_tgt(k, addr);
                exp = pack(6'd0, exp_wd[k], (n >= 3) ? t : 6'd0, 1'b0, (n >= 3) && (t != 0), exp_err[k]);
                act = obs(k); n_cmp++;
                if (act !== exp) begin
                    $display("FAIL read_active dut%0d a=%0d cyc%0d: got %h, expected %h", k, addr, n, act, exp);
                    n_bad++;
                end
            end
            if (n >= 3) a = 3'($urandom_range(0, 7));
        end
        rd_n = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                t   = exp_tgt(k, addr);
                exp = pack(6'd0, exp_wd[k], (n < 3) ? t : 6'd0, n == 3, (n < 3) && (t != 0), exp_err[k]);
                act = obs(k); n_cmp++;
                if (act !== exp) begin
                    $display("FAIL read_release dut%0d a=%0d cyc%0d: got %h, expected %h", k, addr, n, act, exp);
                    n_bad++;
                end
            end
        end
        cs_n = 1'b1;
        $display("read a=%0d hold=%0d", addr, hold);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 1)
                test_write(3'($urandom_range(0, 7)), 16'($urandom), int'($urandom_range(1, 4)));
            else
                test_read(3'($urandom_range(0, 7)), int'($urandom_range(3, 6)));
        end
    endtask

    // CS_n lifted while WR_n is still low: access aborted, no pulse.
    task automatic test_cs_abort();
        logic [30:0] act, exp;
        logic [15:0] data;
        data = 16'($urandom);
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; a = 3'd1; d = data;
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        for (int k = 0; k < 3; k++) exp_wd[k] = data & dmask(k);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                exp = pack(6'd0, exp_wd[k], 6'd0, 1'b0, 1'b0, exp_err[k]);
                act = obs(k); n_cmp++;
                if (act !== exp) begin
                    $display("FAIL cs_abort dut%0d cyc%0d: got %h, expected %h", k, n, act, exp);
                    n_bad++;
                end
            end
            if (n == 6) wr_n = 1'b1;
        end
        $display("cs_abort d=%h", data);
        test_write(3'd0, 16'($urandom), 2);
    endtask

    // WR_n high for a single cycle between two writes: both pulses appear.
    task automatic test_back_to_back();
        logic [30:0] act, exp, msk;
        logic [2:0]  a1, a2;
        logic [15:0] d1, d2, wd;
        logic [5:0]  wp;
        a1 = 3'($urandom_range(0, 7)); a2 = 3'($urandom_range(0, 7));
        d1 = 16'($urandom);            d2 = 16'($urandom);
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; a = a1; d = d1;
        repeat (2) @(negedge clk);
        wr_n = 1'b1;
        for (int n = 3; n <= 10; n++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                wp  = (n == 5) ? exp_tgt(k, a1) : (n == 8) ? exp_tgt(k, a2) : 6'd0;
                wd  = (n == 5) ? (d1 & dmask(k)) : (d2 & dmask(k));
                exp = pack(wp, wd, 6'd0, 1'b0, 1'b0, exp_err[k]);
                msk = (n < 5) ? WD_OFF : '1;
                act = obs(k); n_cmp++;
                if ((act & msk) !== (exp & msk)) begin
                    $display("FAIL back_to_back dut%0d cyc%0d: got %h, expected %h", k, n, act, exp);
                    n_bad++;
                end
            end
            if (n == 3) begin wr_n = 1'b0; a = a2; d = d2; end
            if (n == 5) wr_n = 1'b1;
        end
        cs_n = 1'b1;
        for (int k = 0; k < 3; k++) exp_wd[k] = d2 & dmask(k);
        $display("back_to_back a1=%0d a2=%0d", a1, a2);
    endtask

    // RD_n and WR_n low together: sticky err, no pulses, then recovery.
    task automatic test_conflict();
        logic [30:0] act, exp;
        @(negedge clk);
        cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; a = 3'd2; d = 16'($urandom);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (n >= 3) for (int k = 0; k < 3; k++) exp_err[k] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                exp = pack(6'd0, exp_wd[k], 6'd0, 1'b0, 1'b0, exp_err[k]);
                act = obs(k); n_cmp++;
                if (act !== exp) begin
                    $display("FAIL conflict dut%0d cyc%0d: got %h, expected %h", k, n, act, exp);
                    n_bad++;
                end
            end
            if (n == 4) begin rd_n = 1'b1; wr_n = 1'b1; end
        end
        cs_n = 1'b1;
        $display("conflict: err raised and held");
        test_read(3'd2, 3);
        test_write(3'd1, 16'($urandom), 2);
    endtask

    // Reset during a read clears outputs at once and suppresses rd_done.
    task automatic test_reset_mid_read();
        logic [30:0] act, exp;
        @(negedge clk);
        cs_n = 1'b0; rd_n = 1'b0; a = 3'd2;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            exp = pack(6'd0, exp_wd[k], exp_tgt(k, 3'd2), 1'b0, exp_tgt(k, 3'd2) != 0, exp_err[k]);
            act = obs(k); n_cmp++;
            if (act !== exp) begin
                $display("FAIL pre_rst_read dut%0d: got %h, expected %h", k, act, exp); n_bad++;
            end
        end
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_wd[k] = '0; exp_err[k] = 1'b0;
            act = obs(k); n_cmp++;
            if (act !== 31'd0) begin
                $display("FAIL rst_async dut%0d: got %h, expected %h", k, act, 31'd0); n_bad++;
            end
        end
        rd_n = 1'b1; cs_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                act = obs(k); n_cmp++;
                if (act !== 31'd0) begin
                    $display("FAIL post_rst dut%0d cyc%0d: got %h, expected %h", k, n, act, 31'd0);
                    n_bad++;
                end
            end
        end
        $display("reset_mid_read: outputs cleared, no rd_done");
        test_write(3'd2, 16'h5A5A, 2);
        test_write(3'd5, 16'hC3C3, 2);
    endtask

    initial begin
        test_reset();
        test_write(3'd1, 16'h3CA5, 3);
        test_write(3'd3, 16'h0036, 2);
        test_read(3'd2, 4);
        test_write(3'd7, 16'h1234, 2);
        test_write(3'd4, 16'hBEEF, 2);
        test_random();
        test_cs_abort();
        test_back_to_back();
        test_conflict();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
